// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame constants
// and the cycles-per-bit calculation that the receiver side reuses.
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;

    // Integer truncation is deliberate: a clock that is not an exact multiple
    // of the baud rate rounds the bit period down.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between the datapath store path and the UART transmitter.
interface uart_transmitter_if;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;

    modport master (output DataIn, output DataInValid, input DataInReady);
    modport slave  (input DataIn, input DataInValid, output DataInReady);
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO with an extra pointer MSB to tell full from empty.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [7:0]                  din,
    output logic [7:0]                  dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        push_ok;
    logic        pop_ok;

    // A push while full is refused even if a pop frees a slot on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign dout  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1 serial transmitter: bytes queue in a small FIFO and are sent
// LSB first on SOut, back to back when the queue stays non-empty.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    uart_transmitter_if.slave           tx_if,
    output logic                        SOut,
    output logic                        Busy,
    output logic [$clog2(FIFO_DEPTH):0] Count
);
    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W            = counter_width(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             sout_reg, sout_next;

    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       symbol_done;

    assign tx_if.DataInReady = !fifo_full && reset_n;

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .push    (tx_if.DataInValid && tx_if.DataInReady),
        .pop     (fifo_pop),
        .din     (tx_if.DataIn),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (Count)
    );

    assign symbol_done = (baud_cnt_reg == CNT_LAST);

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        fifo_pop      = 1'b0;

        if (state_reg != IDLE) begin
            baud_cnt_next = symbol_done ? '0 : baud_cnt_reg + 1'b1;
        end

        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_next    = fifo_dout;
                    baud_cnt_next = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (symbol_done) begin
                    bit_idx_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (symbol_done) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == BIT_LAST) state_next = STOP;
                    else bit_idx_next = bit_idx_reg + 1'b1;
                end
            end
            STOP: begin
                // Chaining straight into the next start bit keeps frames gap-free.
                if (symbol_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // SOut is registered from the state being entered, so it changes only on the edge.
        unique case (state_next)
            START:   sout_next = 1'b0;
            DATA:    sout_next = shift_next[0];
            default: sout_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            sout_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            sout_reg     <= sout_next;
        end
    end

    assign SOut = sout_reg;
    assign Busy = (state_reg != IDLE) || (Count != '0);

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a line monitor decodes frames and
// checks them against a scoreboard filled as bytes are offered.
module tb_uart_transmitter;

    localparam int SET = 10;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       sout, busy, sout2, busy2;
    logic [2:0] count, count2;

    always #5 CLK = ~CLK;

    uart_transmitter_if bus ();
    uart_transmitter_if bus2 ();

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .reset_n(reset_n), .tx_if(bus),
        .SOut(sout), .Busy(busy), .Count(count)
    );

    uart_transmitter #(.CLOCK_FREQ(1005), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut2 (
        .CLK(CLK), .reset_n(reset_n), .tx_if(bus2),
        .SOut(sout2), .Busy(busy2), .Count(count2)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        bus.DataInValid = v;
        bus.DataIn      = d;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    // Line monitor: mid-bit sampling of each frame on the main instance.
    initial begin
        logic       active = 1'b0;
        logic       prev   = 1'b1;
        int         cnt    = 0;
        logic [7:0] rx     = '0;
        logic [7:0] want;
        forever begin
            @(negedge CLK);
            if (!reset_n) begin
                active = 1'b0;
                prev   = 1'b1;
            end else if (!active) begin
                if (prev && !sout) begin
                    active = 1'b1;
                    cnt    = 0;
                end
                prev = sout;
            end else begin
                cnt++;
                if (cnt == SET/2) begin
                    check("start_bit", 32'(sout), 0);
                end else if (cnt >= SET + SET/2 && cnt < 9*SET && ((cnt - SET/2) % SET) == 0) begin
                    rx[(cnt - SET - SET/2) / SET] = sout;
                end else if (cnt == 9*SET + SET/2) begin
                    check("stop_bit", 32'(sout), 1);
                    check("frame_expected", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        want = sb.pop_front();
                        check("frame_byte", 32'(rx), 32'(want));
                        $display("frame: got 0x%02h expected 0x%02h", rx, want);
                    end
                    active = 1'b0;
                    prev   = 1'b1;
                end
            end
        end
    end

    initial begin
        int lows;
        int errs;
        logic exp_bit;
        logic [7:0] pat;

        drive(1'b0, 8'h00);
        bus2.DataInValid = 1'b0;
        bus2.DataIn      = 8'h00;

        // Reset state
        repeat (3) tick();
        check("rst_sout",  32'(sout), 1);
        check("rst_busy",  32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(bus.DataInReady), 0);
        reset_n = 1'b1;
        tick();
        check("ready_after_release", 32'(bus.DataInReady), 1);

        // Single byte 0xA5
        drive(1'b1, 8'hA5); sb.push_back(8'hA5);
        tick();
        drive(1'b0, 8'h00);
        check("t1_busy_push", 32'(busy), 1);
        check("t1_sout_idle", 32'(sout), 1);
        tick();
        check("t1_start_low", 32'(sout), 0);
        check("t1_count_popped", 32'(count), 0);
        repeat (9) tick();
        check("t1_start_last", 32'(sout), 0);
        tick();
        check("t1_bit0", 32'(sout), 1);
        repeat (89) tick();
        check("t1_busy_last", 32'(busy), 1);
        tick();
        check("t1_busy_done", 32'(busy), 0);
        check("t1_sout_done", 32'(sout), 1);
        $display("t1: single byte 0xA5 sent");

        // Back-to-back 0x00 then 0xFF
        drive(1'b1, 8'h00); sb.push_back(8'h00);
        tick();
        drive(1'b1, 8'hFF); sb.push_back(8'hFF);
        tick();
        drive(1'b0, 8'h00);
        check("t3_start0", 32'(sout), 0);
        repeat (99) tick();
        check("t3_stop0", 32'(sout), 1);
        tick();
        check("t3_start1_no_gap", 32'(sout), 0);
        check("t3_count", 32'(count), 0);
        wait_idle("t3", 300);
        $display("t3: back-to-back frames sent");

        // Fill, overflow, and held-valid while full
        for (int e = 1; e <= 250; e++) begin
            drive(1'b1, 8'(e));
            if (e <= 5 || e == 103 || e == 203) sb.push_back(8'(e));
            tick();
            if (e == 1)   check("t2_count_e1", 32'(count), 1);
            if (e == 2)   check("t2_count_e2", 32'(count), 1);
            if (e == 5)   check("t2_count_full", 32'(count), 4);
            if (e == 5)   check("t2_ready_full", 32'(bus.DataInReady), 0);
            if (e == 6)   check("t2_reject_count", 32'(count), 4);
            if (e == 102) check("t5_ready_after_pop", 32'(bus.DataInReady), 1);
            if (e == 103) check("t5_count_refill", 32'(count), 4);
            if (e == 250) check("t5_count_end", 32'(count), 4);
        end
        drive(1'b0, 8'h00);
        $display("t2/t5: fill and held-valid phase done");
        wait_idle("t5", 800);

        // Reset during data bit 4 of 0x3C with two bytes queued
        drive(1'b1, 8'h3C); sb.push_back(8'h3C);
        tick();
        drive(1'b1, 8'h11); sb.push_back(8'h11);
        tick();
        drive(1'b1, 8'h22); sb.push_back(8'h22);
        tick();
        drive(1'b0, 8'h00);
        repeat (53) tick();
        check("t4_count_before", 32'(count), 2);
        check("t4_busy_before", 32'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("t4_rst_sout",  32'(sout), 1);
        check("t4_rst_count", 32'(count), 0);
        check("t4_rst_busy",  32'(busy), 0);
        check("t4_rst_ready", 32'(bus.DataInReady), 0);
        sb.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (sout !== 1'b1) lows++;
        end
        check("t4_line_quiet", 32'(lows), 0);
        check("t4_busy_after", 32'(busy), 0);
        $display("t4: mid-frame reset, line quiet afterwards");

        // Truncated bit period on the 1005 Hz instance
        pat = 8'h55;
        bus2.DataInValid = 1'b1;
        bus2.DataIn      = pat;
        tick();
        bus2.DataInValid = 1'b0;
        tick();
        errs = 0;
        for (int c = 0; c < 100; c++) begin
            if (c / 10 == 0)      exp_bit = 1'b0;
            else if (c / 10 == 9) exp_bit = 1'b1;
            else                  exp_bit = pat[c / 10 - 1];
            if (sout2 !== exp_bit) errs++;
            if (c == 99) check("t6_busy_last", 32'(busy2), 1);
            tick();
        end
        check("t6_pattern", 32'(errs), 0);
        check("t6_busy_done", 32'(busy2), 0);
        check("t6_sout_done", 32'(sout2), 1);
        $display("t6: 0x55 frame on truncated clock measured");

        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
